// File: rtl/prescaler_sequencer_if.sv
// Control/status bundle between the register block and the prescaler sequencer.
interface prescaler_sequencer_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);
  logic             ce;
  logic             start;
  logic             stop;
  logic             cfg_we;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_cnt;
  logic             cfg_mode;
  logic             ceo;
  logic             busy;
  logic             done;
  logic             cfg_pend;
  logic [CNT_W-1:0] ticks_left;

  modport master (
    output ce, start, stop, cfg_we, cfg_div, cfg_cnt, cfg_mode,
    input  ceo, busy, done, cfg_pend, ticks_left
  );

  modport slave (
    input  ce, start, stop, cfg_we, cfg_div, cfg_cnt, cfg_mode,
    output ceo, busy, done, cfg_pend, ticks_left
  );
endinterface

// File: rtl/prescaler_sequencer.sv
// Prescaler run controller: divide counter emitting a one-cycle CEO tick every
// div_r enabled cycles, continuous or burst mode, with divide-ratio changes
// deferred to the next tick boundary so the tick train never glitches.
module prescaler_sequencer #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 15,
  parameter int CNT_DEFAULT = 0
) (
  input  logic                clk_i,
  input  logic                clr_n_i,
  prescaler_sequencer_if.slave sq_if
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] div_r_q, div_r_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;

  logic             busy;
  logic             ceo;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] wr_div;
  logic [CNT_W-1:0] eff_cnt;
  logic             eff_mode;

  // A written ratio of 0 would never wrap; treat it as 1.
  assign wr_div   = (sq_if.cfg_div == '0) ? ONE_D : sq_if.cfg_div;
  // A write in the START cycle governs the run it starts.
  assign eff_cnt  = sq_if.cfg_we ? sq_if.cfg_cnt  : cnt_r_q;
  assign eff_mode = sq_if.cfg_we ? sq_if.cfg_mode : mode_q;

  assign div_m1 = div_r_q - ONE_D;
  assign busy   = (state_q == RUN);
  // Tick is a pure decode of registered state gated by CE.
  assign ceo    = busy && sq_if.ce && (q_q == div_m1);

  assign sq_if.ceo        = ceo;
  assign sq_if.busy       = busy;
  assign sq_if.done       = done_q;
  assign sq_if.cfg_pend   = pend_q;
  assign sq_if.ticks_left = (mode_q && busy) ? rem_q : '0;

  // State and configuration registers.
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q  <= IDLE;
      q_q      <= '0;
      div_r_q  <= DIV_W'(DIV_DEFAULT);
      div_sh_q <= DIV_W'(DIV_DEFAULT);
      cnt_r_q  <= CNT_W'(CNT_DEFAULT);
      rem_q    <= '0;
      mode_q   <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      div_r_q  <= div_r_d;
      div_sh_q <= div_sh_d;
      cnt_r_q  <= cnt_r_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
    end
  end

  // Next-state: STOP beats START beats counting.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    div_r_d  = div_r_q;
    div_sh_d = div_sh_q;
    cnt_r_d  = cnt_r_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sq_if.cfg_we) begin
          div_r_d = wr_div;
          cnt_r_d = sq_if.cfg_cnt;
          mode_d  = sq_if.cfg_mode;
          pend_d  = 1'b0;
        end
        if (sq_if.start && !sq_if.stop) begin
          if (eff_mode && (eff_cnt == '0)) begin
            done_d = 1'b1;             // empty burst completes immediately
          end else begin
            state_d = RUN;
            q_d     = '0;
            rem_d   = eff_cnt;
          end
        end
      end
      RUN: begin
        if (sq_if.stop) begin
          state_d = IDLE;
          q_d     = '0;
          // Leaving RUN: any ratio update lands now; a write in this cycle wins.
          if (sq_if.cfg_we) begin
            div_r_d = wr_div;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            div_r_d = div_sh_q;
            pend_d  = 1'b0;
          end
        end else begin
          if (ceo) begin
            q_d = '0;
            if (pend_q) begin
              div_r_d = div_sh_q;
              pend_d  = 1'b0;
            end
            if (mode_q) begin
              if (rem_q == ONE_C) begin
                state_d = IDLE;
                rem_d   = '0;
                done_d  = 1'b1;
              end else if (rem_q != '0) begin
                rem_d = rem_q - ONE_C;
              end
            end
          end else if (sq_if.ce) begin
            q_d = q_q + ONE_D;
          end
          // Writes made while running wait for the following wrap; if this
          // edge ends the burst there is no wrap left, so apply directly.
          if (sq_if.cfg_we) begin
            if (state_d == IDLE) begin
              div_r_d = wr_div;
              pend_d  = 1'b0;
            end else begin
              div_sh_d = wr_div;
              pend_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
